dp_exec_ctrl: RTL and testbench

- Multi-cycle sequencer for ARM data-processing instructions.
- Accepts one 32-bit instruction per handshake and reads Rn/Rm from the register file.
- Forms operand 2: rotated immediate, or register with immediate shift.
- Evaluates the condition field against its own NZCV flag register, drives the combinational alu block, and commits the result and flags.
- Sits between the decode stage and the register-file/alu datapath.

---
 rtl/dp_exec_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_dp_exec_ctrl.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dp_exec_ctrl.sv
// dp_exec_ctrl: four-state sequencer (IDLE/READ/EXEC/WB) for ARM data-processing
// instructions. One instruction is accepted per handshake in IDLE. Rn/Rm are read
// from the register file and operand 2 is formed (a rotated immediate, or a
// register shifted by an immediate amount). The instruction's condition is
// evaluated against the local NZCV register, the external alu is driven, and the
// result and flags are committed in WB.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   instr_valid/instr/instr_ready   instruction handshake (accepted only in IDLE)
//   rf_raddr1/2, rf_rdata1/2    register-file read; data arrives one cycle after the address
//   alu_*                       combinational alu interface, driven only in EXEC
//   alu_result/alu_nzcv/alu_wb  alu response, registered at the end of EXEC
//   rf_we/rf_waddr/rf_wdata     register-file write in WB
//   nzcv                        architectural flags {N,Z,C,V}
//   done/executed               completion pulse in WB; executed = condition passed
//   err                         one-cycle pulse after an unsupported instruction is offered
module dp_exec_ctrl #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         instr_valid,
    input  logic [31:0]  instr,
    output logic         instr_ready,
    output logic [3:0]   rf_raddr1,
    output logic [3:0]   rf_raddr2,
    input  logic [N-1:0] rf_rdata1,
    input  logic [N-1:0] rf_rdata2,
    output logic [3:0]   alu_opcode,
    output logic [N-1:0] alu_op1,
    output logic [N-1:0] alu_op2,
    output logic [3:0]   alu_nzcv_old,
    output logic         alu_c_shift,
    input  logic [N-1:0] alu_result,
    input  logic [3:0]   alu_nzcv,
    input  logic         alu_wb,
    output logic         rf_we,
    output logic [3:0]   rf_waddr,
    output logic [N-1:0] rf_wdata,
    output logic [3:0]   nzcv,
    output logic         done,
    output logic         executed,
    output logic         err
);

    typedef struct packed {
        logic [3:0]  cond;
        logic [1:0]  cls;
        logic        imm;
        logic [3:0]  opcode;
        logic        s;
        logic [3:0]  rn;
        logic [3:0]  rd;
        logic [11:0] op2f;
    } dp_instr_t;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_EXEC = 2'd2;
    localparam logic [1:0] S_WB   = 2'd3;

    logic [1:0]   state;
    dp_instr_t    iq;
    dp_instr_t    dec;
    logic [N-1:0] res_q;
    logic [3:0]   flags_q;
    logic         exec_q, we_q, fl_q, err_q;

    // Condition check on {N,Z,C,V}.
    function automatic logic cond_pass(input logic [3:0] cc, input logic [3:0] f);
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (cc)
            4'h0: cond_pass = z;
            4'h1: cond_pass = ~z;
            4'h2: cond_pass = c;
            4'h3: cond_pass = ~c;
            4'h4: cond_pass = n;
            4'h5: cond_pass = ~n;
            4'h6: cond_pass = v;
            4'h7: cond_pass = ~v;
            4'h8: cond_pass = c & ~z;
            4'h9: cond_pass = ~c | z;
            4'hA: cond_pass = (n == v);
            4'hB: cond_pass = (n != v);
            4'hC: cond_pass = ~z & (n == v);
            4'hD: cond_pass = z | (n != v);
            4'hE: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    endfunction

    // Decode of the offered word.
    logic dec_test, dec_unsup;
    assign dec       = dp_instr_t'(instr);
    assign dec_test  = (dec.opcode[3:2] == 2'b10);   // TST/TEQ/CMP/CMN never write Rd
    assign dec_unsup = (dec.cls != 2'b00)
                     | (~dec.imm & instr[4])
                     | ((dec.rd == 4'd15) & ~dec_test);

    // Operand-2 shifter.
    logic [4:0]   amt, rot;
    logic [N-1:0] imm32, rm, op2;
    logic         c_in, c_sh;

    assign amt   = iq.op2f[11:7];
    assign rot   = {iq.op2f[11:8], 1'b0};
    assign imm32 = {24'b0, iq.op2f[7:0]};
    assign rm    = rf_rdata2;
    assign c_in  = nzcv[1];

    always_comb begin
        op2  = '0;
        c_sh = 1'b0;
        if (iq.imm) begin
            // 5'd0 - rot is 32 - rot modulo 32; for rot=0 both halves equal imm32.
            op2  = (imm32 >> rot) | (imm32 << (5'd0 - rot));
            c_sh = (rot == 5'd0) ? c_in : op2[31];
        end else begin
            case (iq.op2f[6:5])
                2'b00: begin
                    if (amt == 5'd0) begin
                        op2  = rm;
                        c_sh = c_in;
                    end else begin
                        op2  = rm << amt;
                        c_sh = rm[5'd0 - amt];
                    end
                end
                2'b01: begin                      // amount 0 encodes LSR #32
                    if (amt == 5'd0) begin
                        op2  = '0;
                        c_sh = rm[31];
                    end else begin
                        op2  = rm >> amt;
                        c_sh = rm[amt - 5'd1];
                    end
                end
                2'b10: begin                      // amount 0 encodes ASR #32
                    if (amt == 5'd0) begin
                        op2  = {N{rm[31]}};
                        c_sh = rm[31];
                    end else begin
                        op2  = N'($signed(rm) >>> amt);
                        c_sh = rm[amt - 5'd1];
                    end
                end
                default: begin                    // amount 0 encodes RRX
                    if (amt == 5'd0) begin
                        op2  = {c_in, rm[31:1]};
                        c_sh = rm[0];
                    end else begin
                        op2  = (rm >> amt) | (rm << (5'd0 - amt));
                        c_sh = rm[amt - 5'd1];
                    end
                end
            endcase
        end
    end

    // EXEC-cycle qualifiers.
    logic ex_cond, ex_test, ex_noop;
    assign ex_cond = cond_pass(iq.cond, nzcv);
    assign ex_test = (iq.opcode[3:2] == 2'b10);
    assign ex_noop = ex_test & ~iq.s;             // compare ops without S: passed no-op

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            iq      <= '0;
            res_q   <= '0;
            flags_q <= '0;
            exec_q  <= 1'b0;
            we_q    <= 1'b0;
            fl_q    <= 1'b0;
            err_q   <= 1'b0;
            nzcv    <= '0;
        end else begin
            err_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (instr_valid) begin
                        if (dec_unsup) begin
                            err_q <= 1'b1;
                        end else begin
                            iq    <= dec;
                            state <= S_READ;
                        end
                    end
                end
                S_READ: state <= S_EXEC;
                S_EXEC: begin
                    res_q   <= alu_result;
                    flags_q <= alu_nzcv;
                    exec_q  <= ex_cond | ex_noop;
                    we_q    <= ex_cond & alu_wb & ~ex_test;
                    fl_q    <= ex_cond & iq.s;
                    state   <= S_WB;
                end
                default: begin
                    if (fl_q) nzcv <= flags_q;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    logic in_exec;
    assign in_exec      = (state == S_EXEC);
    assign instr_ready  = (state == S_IDLE);
    assign rf_raddr1    = (state == S_READ || in_exec) ? iq.rn : 4'd0;
    assign rf_raddr2    = (state == S_READ || in_exec) ? iq.op2f[3:0] : 4'd0;
    assign alu_opcode   = in_exec ? iq.opcode : 4'd0;
    assign alu_op1      = in_exec ? rf_rdata1 : '0;
    assign alu_op2      = in_exec ? op2 : '0;
    assign alu_nzcv_old = in_exec ? nzcv : 4'd0;
    assign alu_c_shift  = in_exec & c_sh;
    assign done         = (state == S_WB);
    assign executed     = done & exec_q;
    assign rf_we        = done & we_q;
    assign rf_waddr     = rf_we ? iq.rd : 4'd0;
    assign rf_wdata     = rf_we ? res_q : '0;
    assign err          = err_q;

    // Class bits are always zero once latched; bit 4 only matters at decode.
    logic unused_bits;
    assign unused_bits = ^{iq.cls, iq.op2f[4]};

endmodule

// File: tb/tb_dp_exec_ctrl.sv
module tb_dp_exec_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic [31:0] instr = '0;
    logic        instr_ready;
    logic [3:0]  rf_raddr1, rf_raddr2;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic [3:0]  alu_opcode, alu_nzcv_old, alu_nzcv;
    logic [31:0] alu_op1, alu_op2, alu_result;
    logic        alu_c_shift, alu_wb;
    logic        rf_we;
    logic [3:0]  rf_waddr, nzcv;
    logic [31:0] rf_wdata;
    logic        done, executed, err;

    always #5 clk = ~clk;

    dp_exec_ctrl #(.N(32)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .alu_opcode(alu_opcode),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_nzcv_old(alu_nzcv_old),
        .alu_c_shift(alu_c_shift), .alu_result(alu_result), .alu_nzcv(alu_nzcv),
        .alu_wb(alu_wb), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .nzcv(nzcv), .done(done), .executed(executed), .err(err)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ARM data-processing alu: {wb, N, Z, C, V, result}.
    function automatic logic [36:0] alu_fn(input logic [3:0] op, input logic [31:0] a, b,
                                           input logic cs, input logic [3:0] f);
        logic [31:0] x, y, r;
        logic [32:0] s;
        logic cin, arith, c, v;
        x = a; y = b; cin = 1'b0; r = '0; arith = 1'b1;
        case (op)
            4'd0, 4'd8:  begin arith = 1'b0; r = a & b;  end
            4'd1, 4'd9:  begin arith = 1'b0; r = a ^ b;  end
            4'd12:       begin arith = 1'b0; r = a | b;  end
            4'd13:       begin arith = 1'b0; r = b;      end
            4'd14:       begin arith = 1'b0; r = a & ~b; end
            4'd15:       begin arith = 1'b0; r = ~b;     end
            4'd2, 4'd10: begin y = ~b; cin = 1'b1; end
            4'd3:        begin x = b; y = ~a; cin = 1'b1; end
            4'd5:        cin = f[1];
            4'd6:        begin y = ~b; cin = f[1]; end
            4'd7:        begin x = b; y = ~a; cin = f[1]; end
            default:     ;
        endcase
        if (arith) begin
            s = {1'b0, x} + {1'b0, y} + {32'b0, cin};
            r = s[31:0];
            c = s[32];
            v = (x[31] == y[31]) && (r[31] != x[31]);
        end else begin
            c = cs;
            v = f[0];
        end
        return {op[3:2] != 2'b10, r[31], r == 32'd0, c, v, r};
    endfunction

    assign {alu_wb, alu_nzcv, alu_result} = alu_fn(alu_opcode, alu_op1, alu_op2, alu_c_shift, alu_nzcv_old);

    // Register-file environment; preload requests come from the stimulus block.
    logic [31:0] rf [16];
    logic        set_req = 1'b0;
    logic [3:0]  set_idx = '0;
    logic [31:0] set_val = '0;

    always @(posedge clk) begin
        rf_rdata1 <= rf[rf_raddr1];
        rf_rdata2 <= rf[rf_raddr2];
        if (rf_we) rf[rf_waddr] <= rf_wdata;
        if (set_req) rf[set_idx] <= set_val;
    end

    // Reference model: operand 2 as {carry, value} from shift semantics.
    function automatic logic [32:0] m_shift(input logic [31:0] w, rm, input logic c);
        logic [63:0] d;
        logic [32:0] t;
        logic [31:0] o;
        logic co;
        int n;
        if (w[25]) begin
            n  = 2 * int'(w[11:8]);
            d  = {24'b0, w[7:0], 24'b0, w[7:0]} >> n;
            o  = d[31:0];
            co = (n == 0) ? c : o[31];
        end else begin
            n = int'(w[11:7]);
            case (w[6:5])
                2'b00: begin
                    d  = {32'b0, rm} << n;
                    o  = d[31:0];
                    co = (n == 0) ? c : d[32];
                end
                2'b01: begin
                    if (n == 0) n = 32;
                    t  = {rm, 1'b0} >> n;
                    o  = t[32:1];
                    co = t[0];
                end
                2'b10: begin
                    if (n == 0) n = 32;
                    t  = 33'($signed({rm, 1'b0}) >>> n);
                    o  = t[32:1];
                    co = t[0];
                end
                default: begin
                    if (n == 0) begin
                        o  = {c, rm[31:1]};
                        co = rm[0];
                    end else begin
                        d  = {rm, rm} >> n;
                        o  = d[31:0];
                        co = o[31];
                    end
                end
            endcase
        end
        return {co, o};
    endfunction

    function automatic logic m_cond(input logic [3:0] cc, input logic [3:0] f);
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (cc)
            4'h0: return z;          4'h1: return !z;
            4'h2: return c;          4'h3: return !c;
            4'h4: return n;          4'h5: return !n;
            4'h6: return v;          4'h7: return !v;
            4'h8: return c && !z;    4'h9: return !c || z;
            4'hA: return n == v;     4'hB: return n != v;
            4'hC: return !z && n == v;
            4'hD: return z || n != v;
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Model state. cyc counts rising edges; an instruction accepted at edge k
    // occupies the cycles after edges k, k+1, k+2 and commits at edge k+3.
    int          cyc = 0;
    int          k = 0;
    bit          pend = 0;
    bit          err_exp = 0;
    logic [31:0] m_regs [16];
    logic [3:0]  m_nzcv = '0;
    logic        e_exec, e_we, e_flag, e_cs;
    logic [3:0]  e_rd, e_rn, e_rm, e_opc, e_nz;
    logic [31:0] e_res, e_op1, e_op2;

    task automatic model_accept(input logic [31:0] w);
        logic [36:0] r;
        logic test, ok;
        test = (w[24:23] == 2'b10);
        if (w[27:26] != 2'b00 || (!w[25] && w[4]) || (w[15:12] == 4'd15 && !test)) begin
            err_exp = 1;
        end else begin
            pend  = 1;
            k     = cyc;
            e_rn  = w[19:16];
            e_rm  = w[3:0];
            e_rd  = w[15:12];
            e_opc = w[24:21];
            e_op1 = m_regs[e_rn];
            {e_cs, e_op2} = m_shift(w, m_regs[e_rm], m_nzcv[1]);
            r      = alu_fn(e_opc, e_op1, e_op2, e_cs, m_nzcv);
            e_res  = r[31:0];
            e_nz   = r[35:32];
            ok     = m_cond(w[31:28], m_nzcv);
            e_exec = ok || (test && !w[20]);
            e_we   = ok && !test;
            e_flag = ok && w[20];
        end
    endtask

    always @(posedge clk) begin : model
        bit idle;
        cyc++;
        idle    = !pend;
        err_exp = 0;
        if (set_req) m_regs[set_idx] = set_val;
        if (!rst_n) begin
            pend   = 0;
            m_nzcv = '0;
        end else begin
            if (pend && cyc == k + 3) begin
                if (e_we) m_regs[e_rd] = e_res;
                if (e_flag) m_nzcv = e_nz;
                pend = 0;
            end
            if (idle && instr_valid) model_accept(instr);
        end
    end

    // Per-cycle comparison against the model.
    bit chk_en = 0;
    always @(negedge clk) begin : compare
        bit ed;
        if (chk_en) begin
            ed = pend && (cyc == k + 2);
            check("instr_ready", 32'(instr_ready), 32'(!pend));
            check("done", 32'(done), 32'(ed));
            check("err", 32'(err), 32'(err_exp));
            check("rf_we", 32'(rf_we), 32'(ed && e_we));
            check("nzcv", 32'(nzcv), 32'(m_nzcv));
            if (ed) begin
                check("executed", 32'(executed), 32'(e_exec));
                if (e_we) begin
                    check("rf_waddr", 32'(rf_waddr), 32'(e_rd));
                    check("rf_wdata", rf_wdata, e_res);
                end
            end
            if (pend && (cyc == k || cyc == k + 1)) begin
                check("rf_raddr1", 32'(rf_raddr1), 32'(e_rn));
                check("rf_raddr2", 32'(rf_raddr2), 32'(e_rm));
            end
            if (pend && cyc == k + 1) begin
                check("alu_opcode", 32'(alu_opcode), 32'(e_opc));
                check("alu_op1", alu_op1, e_op1);
                check("alu_op2", alu_op2, e_op2);
                check("alu_c_shift", 32'(alu_c_shift), 32'(e_cs));
                check("alu_nzcv_old", 32'(alu_nzcv_old), 32'(m_nzcv));
            end
        end
    end

    // Stimulus.
    bit junk_en = 0;
    int last_acc = 0;

    task automatic set_reg(input logic [3:0] r, input logic [31:0] v);
        @(negedge clk);
        set_req = 1'b1; set_idx = r; set_val = v;
        @(negedge clk);
        set_req = 1'b0;
    endtask

    // Offers w once instr_ready is seen; returns at the falling edge right after
    // the handshake edge (the READ cycle, or the err cycle).
    task automatic issue(input logic [31:0] w);
        int n;
        n = 0;
        @(negedge clk);
        while (instr_ready !== 1'b1 && n < 40) begin
            instr_valid = junk_en ? 1'($urandom_range(0, 1)) : 1'b0;
            instr = $urandom;
            n++;
            @(negedge clk);
        end
        if (n >= 40) check("issue_timeout", 32'(n), 32'd0);
        instr_valid = 1'b1;
        instr = w;
        @(posedge clk);
        #1 last_acc = cyc;
        @(negedge clk);
        instr_valid = 1'b0;
    endtask

    task automatic run(input logic [31:0] w, output logic ex, output logic we,
                       output logic [3:0] wa, output logic [31:0] wd,
                       output logic [3:0] nz, output int lat);
        int n;
        issue(w);
        n = 0;
        while (done !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (n >= 10) check("done_timeout", 32'(n), 32'd0);
        ex = executed; we = rf_we; wa = rf_waddr; wd = rf_wdata;
        lat = cyc + 1 - last_acc;      // cycle after edge e is numbered e+1
        @(negedge clk);
        nz = nzcv;
    endtask

    function automatic logic [31:0] gen();
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 3) == 0) w[31:28] = 4'hE;
        w[27:26] = ($urandom_range(0, 15) == 0) ? 2'b01 : 2'b00;
        if (!w[25]) w[4] = ($urandom_range(0, 15) == 0);
        if (w[15:12] == 4'd15 && $urandom_range(0, 7) != 0) w[15:12] = 4'($urandom_range(0, 14));
        if ($urandom_range(0, 7) == 0) w[3:0] = w[19:16];
        return w;
    endfunction

    initial begin : stim
        logic ex, we;
        logic [3:0] wa, nz;
        logic [31:0] wd;
        int lat, a0;
        for (int i = 0; i < 16; i++) set_reg(4'(i), $urandom);
        @(negedge clk);
        chk_en = 1;
        check("rst_ready", 32'(instr_ready), 32'd1);
        check("rst_nzcv", 32'(nzcv), 32'd0);
        check("rst_outs", {rf_we, done, executed, err}, 32'd0);
        check("rst_alu", alu_op1 | alu_op2 | 32'(alu_opcode) | 32'(rf_raddr1), 32'd0);
        rst_n = 1'b1;

        run(32'hE3B014FF, ex, we, wa, wd, nz, lat);      // MOVS R1,#0xFF000000
        check("movs_lat", 32'(lat), 32'd3);
        check("movs_we", {we, wa}, {27'd0, 1'b1, 4'd1});
        check("movs_wdata", wd, 32'hFF000000);
        check("movs_nzcv", 32'(nz), 32'b1010);

        set_reg(4'd2, 32'd5);
        set_reg(4'd3, 32'd5);
        run(32'hE1520003, ex, we, wa, wd, nz, lat);      // CMP R2,R3
        check("cmp_we", 32'(we), 32'd0);
        check("cmp_nzcv", 32'(nz), 32'b0110);
        run(32'h10824003, ex, we, wa, wd, nz, lat);      // ADDNE R4,R2,R3
        check("addne_exec", {ex, we}, 32'd0);
        check("addne_nzcv", 32'(nz), 32'b0110);
        run(32'h00824003, ex, we, wa, wd, nz, lat);      // ADDEQ R4,R2,R3
        check("addeq_wdata", wd, 32'd10);
        run(32'hE092A003, ex, we, wa, wd, nz, lat);      // ADDS R10,R2,R3 clears C
        check("adds10_nzcv", 32'(nz), 32'b0000);

        set_reg(4'd5, 32'h80000001);
        run(32'hE1B06065, ex, we, wa, wd, nz, lat);      // MOVS R6,R5,RRX
        check("rrx_wdata", wd, 32'h40000000);
        check("rrx_nzcv", 32'(nz), 32'b0010);
        run(32'hE1B06045, ex, we, wa, wd, nz, lat);      // MOVS R6,R5,ASR #32
        check("asr32_wdata", wd, 32'hFFFFFFFF);
        check("asr32_nzcv", 32'(nz), 32'b1010);

        set_reg(4'd8, 32'h7FFFFFFF);
        set_reg(4'd9, 32'd1);
        run(32'hE0987009, ex, we, wa, wd, nz, lat);      // ADDS R7,R8,R9
        check("ovf_wdata", wd, 32'h80000000);
        check("ovf_nzcv", 32'(nz), 32'b1001);

        issue(32'hE1A0B007);                             // MOV R11,R7 twice, back to back
        a0 = last_acc;
        issue(32'hE1A0B007);
        check("issue_gap", 32'(last_acc - a0), 32'd4);
        repeat (4) @(negedge clk);

        issue(32'hE5912000);                             // LDR: not data-processing
        check("ldr_err", {err, instr_ready, rf_we}, 32'b110);
        issue(32'hE0010312);                             // register-specified shift
        check("regshift_err", {err, instr_ready, rf_we}, 32'b110);
        repeat (2) @(negedge clk);

        issue(32'hE0987009);                             // reset while in EXEC
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rstx_state", {done, rf_we, 4'(nzcv)}, 32'd0);
        @(negedge clk);
        check("rstx_ready", 32'(instr_ready), 32'd1);
        repeat (4) @(negedge clk);

        junk_en = 1;
        repeat (300) issue(gen());
        repeat (8) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

endmodule
